idx_pingpong_buf: RTL
=====================

# idx_pingpong_buf

Per-PE double-buffered index store, directly downstream of the DDR-to-index-buffer loader. It receives one PE's share of the loader's index write port (one bit of its PE write-enable vector) and keeps two banks. While the loader fills one bank, the PE consumes the other as a valid/ready index stream. Bank ownership is tracked by explicit fill-commit and read-complete events, so loading of the next tile overlaps computation on the current one.

## Interface
Parameters:
- `DEPTH`, 256: entries per bank.
- `ADDR_W`, `bw(DEPTH)`: bank address width.
- `IDX_W`, `GLOBAL_PARAM::IDX_W`: width of one index. An entry holds an index pair of `2*IDX_W` bits.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset: synchronous, active-low.
- `wr_data`  in  2*IDX_W  index pair from the loader.
- `wr_addr`  in  ADDR_W  entry address within the current write bank.
- `wr_en`  in  1  write strobe; this PE's bit of the loader's enable vector.
- `wr_ready`  out  1  the current write bank is FREE, so writes are accepted.
- `fill_valid`  in  1  commit the current write bank.
- `fill_num`  in  ADDR_W+1  number of valid entries in the committed bank, 0..DEPTH.
- `fill_ready`  out  1  equal to `wr_ready`.
- `idx_data`  out  2*IDX_W  index pair to the PE.
- `idx_valid`  out  1  `idx_data` is valid.
- `idx_ready`  in  1  PE accepts `idx_data`.
- `idx_last`  out  1  marks the final entry of a bank.

## Operation
- Each bank has a state: FREE, FULL or READING. Pointers: `wb` is the write bank and `rb` is the read bank; both are 1 bit and toggle on use.
- Write path:
  - If `wr_en && wr_ready`, the block writes `wr_data` to bank `wb` at `wr_addr`.
  - If `wr_en` is asserted while `!wr_ready`, the write is dropped and a simulation assertion fires.
- Commit: on `fill_valid && fill_ready`:
  - `cnt[wb] <= fill_num`.
  - `state[wb] <= FULL`.
  - `wb` toggles.
  - `fill_num > DEPTH` is illegal and asserted against.
- Read FSM states: IDLE, READ, DRAIN.
  - IDLE: when `state[rb] == FULL`, mark it READING, clear `raddr`, and go to READ. If `cnt[rb] == 0`, instead set the bank FREE, toggle `rb` and stay in IDLE; nothing is emitted.
  - READ: issue a RAM read at `raddr` whenever the output FIFO has a free slot, counting in-flight reads. Increment `raddr`. After `raddr == cnt-1` is issued, go to DRAIN.
  - DRAIN: wait for the handshake of the entry with `idx_last`. Then set `state[rb] <= FREE`, toggle `rb` and return to IDLE.
- Output is a 2-entry FIFO fed by the RAM's 1-cycle read.
  - `idx_last` is carried per entry and set on the entry for address `cnt-1`.
  - `idx_data` is held stable while `idx_valid && !idx_ready`.
- Simultaneous events: a commit on `wb` and a free on `rb` in the same cycle are both applied. If both banks become FREE, the write side proceeds normally.
- Reset (`rst == 0`, at any time including mid-stream):
  - Both banks FREE; `wb = rb = 0`; FSM in IDLE; FIFO empty.
  - `idx_valid = 0`, `idx_last = 0`, `idx_data = 0`.
  - `wr_ready = fill_ready = 0` during reset and 1 on the first cycle after release.
  - RAM contents are not cleared.

## Timing
- A commit handshake in cycle T gives `idx_valid` high first in T+3 when the other bank is not READING.
- With `idx_ready` held high, throughput is 1 entry/cycle and there are no bubbles inside a bank.
- Back-to-back banks: 2 idle cycles between the `idx_last` handshake and the first entry of the next FULL bank.
- `wr_ready` falls in the cycle after a commit that leaves no FREE bank. It rises in the cycle after the `idx_last` handshake frees a bank.
- A write to a bank is visible to its reads from the cycle after commit; the RAM is write-first.

## Structure
- Shared package `GLOBAL_PARAM` provides `IDX_W` and `bw()`. Add to it a `bank_state_t` enum (FREE, FULL, READING) for reuse by the other ping-pong buffers.
- One sub-module, `sdp_ram`: a simple dual-port RAM with parameterised width and depth and registered 1-cycle read. It is instantiated once with depth `2*DEPTH`; the top address bit selects the bank.
- FSM, counters and FIFO live in the top module.

## Test plan
- Fill bank 0 with entries 0..9 = `k`, commit with `fill_num = 10`, `idx_ready` held at 1 → 10 beats, values 0..9 on consecutive cycles, first beat at T+3, `idx_last` on the beat with value 9.
- Commit bank 0 (4 entries), then fill and commit bank 1 (5 entries) while bank 0 is being read → `wr_ready = 0` after the second commit; 9 beats in order; `wr_ready = 1` one cycle after bank 0's last handshake.
- Randomised `idx_ready` (50%) over `fill_num = 256` → all 256 values in order, no loss or duplication, data stable while stalled.
- `fill_num = 0` commit → no `idx_valid`; bank returns to FREE within 2 cycles.
- Write with `wr_en = 1` while both banks are full → the write is dropped, the assertion fires, and the stored data is unchanged.
- Assert `rst = 0` mid-stream (beat 3 of 8) → next cycle `idx_valid = 0`; after release a new 2-entry commit streams correctly from bank 0.

Source files
------------

// File: rtl/idx_pingpong_buf_pkg.sv
// ---------------------------------------------------------------------------
// GLOBAL_PARAM
// Shared parameters and types for the index-buffer path.
//   IDX_W        : width of one index (an entry stores a pair of them)
//   bw()         : address width needed to address n entries
//   bank_state_t : ownership state of one bank of a ping-pong buffer
//   rd_state_t   : read-side sequencer states of a ping-pong buffer
// ---------------------------------------------------------------------------
package GLOBAL_PARAM;

    localparam int IDX_W = 16;

    // Address width for n entries; never narrower than one bit.
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FULL    = 2'd1,
        READING = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/idx_pingpong_buf_sdp_ram.sv
// ---------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM: one write port, one read port, registered read with
// one cycle of latency. A read and write to the same address in one cycle
// returns the new data (write-first).
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata updates on the following edge
//   raddr : read address
//   rdata : registered read data, holds its value while re is low
// ---------------------------------------------------------------------------
module sdp_ram
    import GLOBAL_PARAM::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int AW    = bw(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the read register follows re.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/idx_pingpong_buf.sv
// ---------------------------------------------------------------------------
// idx_pingpong_buf
// Per-PE double-buffered index store. The loader fills one bank while the PE
// streams the other out as a valid/ready index stream. Ownership of each bank
// moves FREE -> FULL (commit) -> READING (read start) -> FREE (last beat).
//   clk        : clock
//   rst        : synchronous active-low reset
//   wr_data    : index pair from the loader
//   wr_addr    : entry address inside the current write bank
//   wr_en      : write strobe
//   wr_ready   : current write bank is FREE
//   fill_valid : commit current write bank
//   fill_num   : number of valid entries in the committed bank (0..DEPTH)
//   fill_ready : same as wr_ready
//   idx_data   : index pair to the PE
//   idx_valid  : idx_data valid
//   idx_ready  : PE accepts idx_data
//   idx_last   : final entry of a bank
// ---------------------------------------------------------------------------
module idx_pingpong_buf #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = GLOBAL_PARAM::bw(DEPTH),
    parameter int IDX_W  = GLOBAL_PARAM::IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*IDX_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic               wr_en,
    output logic               wr_ready,
    input  logic               fill_valid,
    input  logic [ADDR_W:0]    fill_num,
    output logic               fill_ready,
    output logic [2*IDX_W-1:0] idx_data,
    output logic               idx_valid,
    input  logic               idx_ready,
    output logic               idx_last
);

    import GLOBAL_PARAM::*;

    localparam int DW = 2 * IDX_W;
    localparam int CW = ADDR_W + 1;

    bank_state_t       bank_st [2];
    logic [CW-1:0]     cnt [2];
    logic              wb;
    logic              rb;

    rd_state_t         rd_st;
    rd_state_t         rd_nxt;
    logic [ADDR_W-1:0] raddr;

    logic              commit;
    logic              pop;
    logic              room;
    logic              is_last_addr;
    logic              start_bank;
    logic              skip_bank;
    logic              issue;
    logic              free_bank;
    logic              out_last;
    logic [CW-1:0]     cnt_m1;

    // One read in flight toward the output FIFO, with its last flag.
    logic              pend;
    logic              pend_last;
    logic [DW-1:0]     ram_rdata;

    logic [DW-1:0]     fifo_data [2];
    logic              fifo_last [2];
    logic              fifo_rp;
    logic              fifo_wp;
    logic [1:0]        fifo_cnt;
    logic [1:0]        used;
    logic              push;
    logic              fpop;

    // wr_ready is gated by rst so it reads 0 throughout reset and 1 on the
    // first cycle after release, without waiting a clock.
    always_comb begin
        wr_ready   = rst && (bank_st[wb] == FREE);
        fill_ready = wr_ready;
        commit     = fill_valid && fill_ready;
    end

    // Output side: the FIFO head has priority; when the FIFO is empty the
    // RAM's registered read is presented directly so the first beat is not
    // delayed by an extra FIFO stage.
    always_comb begin
        idx_valid = (fifo_cnt != 2'd0) || pend;
        if (fifo_cnt != 2'd0) begin
            idx_data = fifo_data[fifo_rp];
            out_last = fifo_last[fifo_rp];
        end else if (pend) begin
            idx_data = ram_rdata;
            out_last = pend_last;
        end else begin
            idx_data = '0;
            out_last = 1'b0;
        end
        idx_last = out_last;
        pop      = idx_valid && idx_ready;
        // Slots already claimed are FIFO entries plus the read in flight; a
        // beat leaving this cycle frees one, so reads keep 1/cycle flow.
        used     = fifo_cnt + {1'b0, pend};
        room     = (used < 2'd2) || pop;
        push     = pend && !((fifo_cnt == 2'd0) && pop);
        fpop     = (fifo_cnt != 2'd0) && pop;
        cnt_m1       = cnt[rb] - 1'b1;
        is_last_addr = ({1'b0, raddr} == cnt_m1);
    end

    // Read sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_st <= RD_IDLE;
        end else begin
            rd_st <= rd_nxt;
        end
    end

    // Read sequencer next state: claim a FULL bank, issue its reads, then
    // wait for the last beat to be accepted before releasing the bank.
    always_comb begin
        rd_nxt = rd_st;
        case (rd_st)
            RD_IDLE: begin
                if ((bank_st[rb] == FULL) && (cnt[rb] != '0)) begin
                    rd_nxt = RD_READ;
                end
            end
            RD_READ: begin
                if (issue && is_last_addr) begin
                    rd_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (pop && out_last) begin
                    rd_nxt = RD_IDLE;
                end
            end
            default: rd_nxt = RD_IDLE;
        endcase
    end

    // Read sequencer outputs. An empty committed bank is released straight
    // from IDLE without emitting anything.
    always_comb begin
        start_bank = 1'b0;
        skip_bank  = 1'b0;
        issue      = 1'b0;
        free_bank  = 1'b0;
        case (rd_st)
            RD_IDLE: begin
                if (bank_st[rb] == FULL) begin
                    start_bank = (cnt[rb] != '0);
                    skip_bank  = (cnt[rb] == '0);
                end
            end
            RD_READ:  issue = room;
            RD_DRAIN: free_bank = pop && out_last;
            default: ;
        endcase
        free_bank = free_bank || skip_bank;
    end

    // Bank bookkeeping, read address, in-flight tracking and output FIFO.
    // A commit on wb and a release on rb can land in the same cycle; they
    // always target different banks, so both are applied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= FREE;
                cnt[b]     <= '0;
            end
            wb        <= 1'b0;
            rb        <= 1'b0;
            raddr     <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            fifo_rp   <= 1'b0;
            fifo_wp   <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (commit && (wb == 1'(b))) begin
                    bank_st[b] <= FULL;
                    cnt[b]     <= fill_num;
                end else if (free_bank && (rb == 1'(b))) begin
                    bank_st[b] <= FREE;
                end else if (start_bank && (rb == 1'(b))) begin
                    bank_st[b] <= READING;
                end
            end
            if (commit) begin
                wb <= ~wb;
            end
            if (free_bank) begin
                rb <= ~rb;
            end
            if (start_bank) begin
                raddr <= '0;
            end else if (issue) begin
                raddr <= raddr + 1'b1;
            end
            pend      <= issue;
            pend_last <= issue && is_last_addr;
            if (push) begin
                fifo_data[fifo_wp] <= ram_rdata;
                fifo_last[fifo_wp] <= pend_last;
                fifo_wp            <= ~fifo_wp;
            end
            if (fpop) begin
                fifo_rp <= ~fifo_rp;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, fpop};
        end
    end

    // Writes to a bank that is not FREE are dropped; flag them, and flag an
    // entry count larger than a bank, in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(wr_en && !wr_ready));
            if (commit) begin
                assert (fill_num <= CW'(DEPTH));
            end
        end
    end

    sdp_ram #(
        .WIDTH (DW),
        .DEPTH (2 * DEPTH),
        .AW    (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && wr_ready),
        .waddr ({wb, wr_addr}),
        .wdata (wr_data),
        .re    (issue),
        .raddr ({rb, raddr}),
        .rdata (ram_rdata)
    );

endmodule
